// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, FSM states,
// ALU-control codes, trap causes and the instruction classifier.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  typedef enum logic [2:0] {
    RESET,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [1:0] TRAP_NONE     = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL  = 2'b01;
  localparam logic [1:0] TRAP_FETCH_TO = 2'b10;
  localparam logic [1:0] TRAP_DATA_TO  = 2'b11;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ILLEGAL
  } instr_class_t;

  // Only word loads/stores and BEQ are supported; other funct3 values are illegal.
  function automatic instr_class_t classify(input logic [6:0] opcode, input logic [2:0] funct3);
    instr_class_t cls;
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_I:      cls = CLS_I;
      OP_LOAD:   if (funct3 == F3_WORD) cls = CLS_LOAD;
      OP_STORE:  if (funct3 == F3_WORD) cls = CLS_STORE;
      OP_BRANCH: if (funct3 == F3_BEQ)  cls = CLS_BRANCH;
      default:   cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles for the current request; expired flags the last
// permitted cycle so the sequencer can trap if ready is still low.
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != WAIT_LIM)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // WAIT_MAX of zero means wait forever.
  assign expired = (WAIT_MAX != 0) && enable && (cnt_q == WAIT_LIM);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: owns PC/IR, walks FETCH/DECODE/EXEC/MEM/WB and
// drives datapath strobes, with memory wait states and sticky traps.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int unsigned      WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_addr_sel,
  input  logic            mem_ready,
  input  logic [31:0]     mem_rdata,
  output logic            mdr_we,
  output logic [31:0]     ir,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] branch_target,
  input  logic            alu_zero,
  output logic            alu_src,
  output logic [1:0]      alu_op,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic            retire,
  output logic            trap,
  output logic [1:0]      trap_cause
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [1:0]      cause_q, cause_d;

  instr_class_t    cls;
  logic [XLEN-1:0] pc_plus4;
  logic            wait_clear;
  logic            wait_enable;
  logic            wait_expired;

  assign cls      = classify(ir_q[6:0], ir_q[14:12]);
  assign pc_plus4 = pc_q + XLEN'(4);

  // Any state change starts a fresh wait window.
  assign wait_clear  = (state_d != state_q);
  assign wait_enable = mem_req && !mem_ready;

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (wait_clear),
    .enable  (wait_enable),
    .expired (wait_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cause_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cause_d = cause_q;
    case (state_q)
      RESET: state_d = FETCH;
      FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = DECODE;
        end else if (wait_expired) begin
          state_d = TRAP;
          cause_d = TRAP_FETCH_TO;
        end
      end
      DECODE: begin
        if (cls == CLS_ILLEGAL) begin
          state_d = TRAP;
          cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (cls)
          CLS_BRANCH: begin
            pc_d    = alu_zero ? branch_target : pc_plus4;
            state_d = FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = MEM;
          default:             state_d = WB;
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          if (cls == CLS_STORE) begin
            pc_d    = pc_plus4;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (wait_expired) begin
          state_d = TRAP;
          cause_d = TRAP_DATA_TO;
        end
      end
      WB: begin
        pc_d    = pc_plus4;
        state_d = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = RESET;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    mdr_we       = 1'b0;
    alu_src      = 1'b0;
    alu_op       = ALUOP_ADD;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    retire       = 1'b0;
    case (state_q)
      FETCH: mem_req = 1'b1;
      EXEC, MEM: begin
        // ALU controls stay stable through MEM so the address holds.
        case (cls)
          CLS_R: begin
            alu_src = 1'b0;
            alu_op  = ALUOP_FUNCT;
          end
          CLS_I: begin
            alu_src = 1'b1;
            alu_op  = ALUOP_FUNCT;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src = 1'b1;
            alu_op  = ALUOP_ADD;
          end
          CLS_BRANCH: begin
            alu_src = 1'b0;
            alu_op  = ALUOP_SUB;
          end
          default: begin
            alu_src = 1'b0;
            alu_op  = ALUOP_ADD;
          end
        endcase
        if (state_q == EXEC) begin
          retire = (cls == CLS_BRANCH);
        end else begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (cls == CLS_STORE);
          mdr_we       = (cls == CLS_LOAD) && mem_ready;
          retire       = (cls == CLS_STORE) && mem_ready;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == CLS_LOAD);
        retire     = 1'b1;
      end
      default: ;
    endcase
  end

  assign ir         = ir_q;
  assign pc         = pc_q;
  assign trap       = (state_q == TRAP);
  assign trap_cause = cause_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Parametrised multi-cycle sequencer; next generation of the single-cycle core top.
- Owns the PC and instruction register.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes (register file, ALU control, unified memory).
- Sits between the shared memory (valid/ready handshake) and the existing register file, ALU and ALU-control blocks; adds memory wait states, timeout and illegal-instruction trapping.

Parameters:
XLEN, 32, PC and data width
RESET_PC, 0, PC value loaded on reset
WAIT_MAX, 15, max cycles a memory request waits for mem_ready before trap; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
mem_req  out  1  memory request valid
mem_we  out  1  memory write enable (qualified by mem_req)
mem_addr_sel  out  1  memory address source: 0=PC, 1=ALU result
mem_ready  in  1  memory completes current request this cycle
mem_rdata  in  32  memory read data (instruction during fetch)
mdr_we  out  1  datapath latches load data this cycle
ir  out  32  instruction register
pc  out  XLEN  program counter
branch_target  in  XLEN  PC+imm from datapath
alu_zero  in  1  ALU zero flag
alu_src  out  1  0=register, 1=immediate
alu_op  out  2  to ALU control: 00 add, 01 sub, 10 funct-decoded
reg_write  out  1  register-file write strobe
mem_to_reg  out  1  writeback source: 1=load data
retire  out  1  one-cycle pulse per completed instruction
trap  out  1  sticky fault indicator
trap_cause  out  2  00 none, 01 illegal instr, 10 fetch timeout, 11 data timeout

Behaviour:
- Reset (async, immediate): state=RESET; pc=RESET_PC; ir=0; trap=0; trap_cause=00; all strobes and retire 0; wait counter 0. Reset asserted mid-request drops mem_req in the same cycle.
- RESET: one cycle after reset release -> FETCH.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
  - mem_ready=1: ir<=mem_rdata -> DECODE.
  - Else counter increments; counter==WAIT_MAX with no ready (WAIT_MAX>0) -> TRAP, cause 10.
  - Zero-wait fetch costs 1 cycle.
- DECODE (1 cycle):
  - Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD (funct3 010), 0100011 STORE (funct3 010), 1100011 BEQ (funct3 000).
  - Anything else -> TRAP, cause 01; else -> EXEC.
- EXEC (1 cycle):
  - R: alu_src=0, alu_op=10.
  - I-ALU: alu_src=1, alu_op=10.
  - LOAD/STORE: alu_src=1, alu_op=00.
  - BEQ: alu_src=0, alu_op=01; pc<=alu_zero ? branch_target : pc+4; retire=1; -> FETCH.
  - R/I -> WB; LOAD/STORE -> MEM.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE; EXEC ALU outputs held stable.
  - On mem_ready: LOAD asserts mdr_we, -> WB; STORE: pc<=pc+4, retire=1, -> FETCH.
  - Timeout as in FETCH -> TRAP, cause 11; no retire, pc unchanged.
- WB (1 cycle): reg_write=1, mem_to_reg=1 for LOAD; pc<=pc+4; retire=1; -> FETCH.
- TRAP: terminal until reset. trap=1, cause held, all strobes 0, pc/ir frozen.
- Wait counter: width clog2(WAIT_MAX+1); cleared on every state entry.
- mem_ready outside FETCH/MEM is ignored.
- pc+4 wraps modulo 2^XLEN (0xFFFFFFFC -> 0x00000000); branch_target used unmodified.
- Latency at zero wait: BEQ 3 cycles, R/I 4, STORE 4, LOAD 5.
- All outputs are registered-state decodes; no combinational path from mem_ready to mem_req.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH)
  - state enum (RESET, FETCH, DECODE, EXEC, MEM, WB, TRAP)
  - ALU-op codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT)
  - trap-cause codes
- One sub-module: mem_wait_timer (clear, enable, WAIT_MAX -> expired), instantiated once and reused by FETCH and MEM.

Test Plan:
- Reset, then mem_ready always 1, mem_rdata=0x002081B3 (add x3,x1,x2) -> sequence FETCH,DECODE,EXEC,WB; reg_write=1 in WB; retire pulse at cycle 5 after reset release; pc=0x4.
- LOAD 0x0000A183 with mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles with mem_addr_sel=1, mdr_we on ready cycle, WB with mem_to_reg=1, pc+=4.
- BEQ with alu_zero=1, branch_target=0x40 -> pc=0x40 after EXEC, retire=1; repeat with alu_zero=0 -> pc=old+4.
- Fetch with mem_ready never asserted, WAIT_MAX=15 -> trap=1, cause 10 after 16 FETCH cycles; strobes 0, pc frozen. Reset mid-wait on a second run -> mem_req 0 immediately, pc=RESET_PC.
- mem_rdata=0xFFFFFFFF -> DECODE to TRAP, cause 01, no retire.
- RESET_PC=0xFFFFFFFC, one R-type -> pc wraps to 0x00000000.
